// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if -- bundle of the receive-FIFO handshake and status signals.
//   slave  : the FIFO side (takes rx/rd requests, drives read data + status)
//   master : the producer/consumer side (drives rx/rd requests)
//   rx_data/rx_valid : byte strobe from the UART receiver
//   rd_en            : consumer read request
//   clr_overflow     : clears the sticky overflow flag
//   rd_data/rd_valid : registered read data, one-cycle valid pulse
//   empty/full/count : occupancy status
//   overflow         : sticky dropped-byte flag
interface uart_rx_fifo_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] rx_data;
  logic             rx_valid;
  logic             rd_en;
  logic             clr_overflow;
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid;
  logic             empty;
  logic             full;
  logic [CW-1:0]    count;
  logic             overflow;

  modport slave (
    input  rx_data, rx_valid, rd_en, clr_overflow,
    output rd_data, rd_valid, empty, full, count, overflow
  );

  modport master (
    output rx_data, rx_valid, rd_en, clr_overflow,
    input  rd_data, rd_valid, empty, full, count, overflow
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo -- synchronous FIFO buffering bytes from a UART receiver.
//   clk   : single clock, rising edge
//   reset : asynchronous, active-low
//   bus   : uart_rx_fifo_if.slave (rx strobe in, registered read data out,
//           empty/full/count/overflow status)
// A write into a full FIFO is accepted only if a read retires an entry in the
// same cycle; otherwise the byte is dropped and overflow latches. Reads have
// one cycle of latency and never bypass a same-cycle write.
module uart_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic           clk,
  input  logic           reset,
  uart_rx_fifo_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef logic [AW-1:0] ptr_t;

  // Storage is deliberately not reset; count gates every read.
  logic [WIDTH-1:0] mem_q [DEPTH];

  ptr_t             wp_q, wp_d;
  ptr_t             rp_q, rp_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;
  logic             overflow_q, overflow_d;

  logic empty, full, rd_acc, wr_acc, drop;

  always_comb begin
    // Status comes only from the registered count.
    empty  = (count_q == '0);
    full   = (count_q == CW'(DEPTH));
    rd_acc = bus.rd_en & ~empty;
    // A read in the same cycle frees a slot, so full does not block the write.
    wr_acc = bus.rx_valid & (~full | rd_acc);
    drop   = bus.rx_valid & full & ~rd_acc;

    wp_d       = wp_q;
    rp_d       = rp_q;
    count_d    = count_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    overflow_d = overflow_q;

    if (wr_acc) wp_d = wp_q + ptr_t'(1);
    if (rd_acc) begin
      rp_d       = rp_q + ptr_t'(1);
      rd_data_d  = mem_q[rp_q];
      rd_valid_d = 1'b1;
    end

    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // Set beats clear when a drop coincides with clr_overflow.
    if (drop)                  overflow_d = 1'b1;
    else if (bus.clr_overflow) overflow_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wp_q       <= '0;
      rp_q       <= '0;
      count_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wp_q       <= wp_d;
      rp_q       <= rp_d;
      count_q    <= count_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wp_q] <= bus.rx_data;
  end

  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.empty    = empty;
  assign bus.full     = full;
  assign bus.count    = count_q;
  assign bus.overflow = overflow_q;
endmodule
